lfsr_checker: RTL and testbench

- Serial receive-side checker for the 32-bit Fibonacci LFSR stream (taps 0, 1, 21, 31; shift right; feedback into bit 31).
- Transmit side sends q[0] of the generator state each cycle as the stream bit.
- The checker self-synchronises by loading 32 received bits, then verifies further bits against its local prediction.
- Once locked, it flywheels on its own prediction while counting bit errors. Sits at the link/BIST receive end, opposite the lfsr generator.

---
 rtl/lfsr_checker.sv | 148 ++++++++++++++
 tb/tb_lfsr_checker.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 32-bit Fibonacci LFSR stream (taps 0,1,21,31, shift right).
// Define LFSR_CHECKER_BITCNT_EN to add the bit_count output.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT    = 32,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
`ifdef LFSR_CHECKER_BITCNT_EN
    output logic [31:0]      bit_count,
`endif
    output logic [31:0]      state_out
);

    localparam int unsigned RunW  = $clog2(LOCK_CNT + 1);
    localparam int unsigned MissW = $clog2(LOSS_THRESH + 1);
    localparam logic [RunW-1:0]  RunLast  = RunW'(LOCK_CNT - 1);
    localparam logic [MissW-1:0] MissLast = MissW'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {StLoad, StVerify, StLocked} state_e;

    state_e           state_q, state_d;
    logic [31:0]      sr_q, sr_d;
    logic [4:0]       fill_q, fill_d;
    logic [RunW-1:0]  run_q, run_d;
    logic [MissW-1:0] miss_q, miss_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pulse_q, pulse_d;
    logic             locked_q, locked_d;
`ifdef LFSR_CHECKER_BITCNT_EN
    logic [31:0]      bitcnt_q, bitcnt_d;
`endif
    logic             pred;
    logic             match;

    assign pred  = sr_q[0] ^ sr_q[1] ^ sr_q[21] ^ sr_q[31];
    assign match = (din == pred);

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        fill_d   = fill_q;
        run_d    = run_q;
        miss_d   = miss_q;
        err_d    = err_q;
        pulse_d  = 1'b0;
`ifdef LFSR_CHECKER_BITCNT_EN
        bitcnt_d = bitcnt_q;
`endif
        if (din_valid) begin
            unique case (state_q)
                StLoad: begin
                    sr_d   = {din, sr_q[31:1]};
                    fill_d = fill_q + 5'd1;
                    if (fill_q == 5'd31) begin
                        state_d = StVerify;
                        run_d   = '0;
                    end
                end
                StVerify: begin
                    sr_d = {din, sr_q[31:1]};
                    // An all-zero window predicts zeros forever, so it never earns lock.
                    if (match && (sr_q != '0)) begin
                        if (run_q == RunLast) begin
                            state_d = StLocked;
                            miss_d  = '0;
                        end else begin
                            run_d = run_q + RunW'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                StLocked: begin
                    // Flywheel: feed back our own prediction so bad bits never enter sr.
                    sr_d = {pred, sr_q[31:1]};
`ifdef LFSR_CHECKER_BITCNT_EN
                    bitcnt_d = bitcnt_q + 32'd1;
`endif
                    if (!match) begin
                        pulse_d = 1'b1;
                        if (err_q != '1) err_d = err_q + ERR_W'(1);
                        if (miss_q == MissLast) begin
                            state_d = StLoad;
                            fill_d  = '0;
                        end else begin
                            miss_d = miss_q + MissW'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = StLoad;
            endcase
        end
        if (clr_cnt) begin
            err_d    = '0;
`ifdef LFSR_CHECKER_BITCNT_EN
            bitcnt_d = '0;
`endif
        end
        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StLoad;
            sr_q     <= '0;
            fill_q   <= '0;
            run_q    <= '0;
            miss_q   <= '0;
            err_q    <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
`ifdef LFSR_CHECKER_BITCNT_EN
            bitcnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            fill_q   <= fill_d;
            run_q    <= run_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
            pulse_q  <= pulse_d;
            locked_q <= locked_d;
`ifdef LFSR_CHECKER_BITCNT_EN
            bitcnt_q <= bitcnt_d;
`endif
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_count = err_q;
    assign state_out = sr_q;
`ifdef LFSR_CHECKER_BITCNT_EN
    assign bit_count = bitcnt_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus a randomized run against a model.
module tb_lfsr_checker;

    localparam int unsigned LockCnt    = 32;
    localparam int unsigned LossThresh = 4;
    localparam int unsigned ErrW       = 4;
    localparam int          ErrMax     = (1 << ErrW) - 1;
    localparam int          MLoad      = 0;
    localparam int          MVerify    = 1;
    localparam int          MLocked    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            din;
    logic            din_valid;
    logic            clr_cnt;
    logic            locked;
    logic            err_pulse;
    logic [ErrW-1:0] err_count;
    logic [31:0]     state_out;
`ifdef LFSR_CHECKER_BITCNT_EN
    logic [31:0]     bit_count;
`endif

    lfsr_checker #(
        .LOCK_CNT    (LockCnt),
        .LOSS_THRESH (LossThresh),
        .ERR_W       (ErrW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
`ifdef LFSR_CHECKER_BITCNT_EN
        .bit_count (bit_count),
`endif
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transmit generator and history of its state before each valid bit.
    logic [31:0] gen;
    logic [31:0] hist[$];

    // Reference model of the receiver.
    logic [31:0] m_sr;
    int          m_mode, m_fill, m_run, m_miss, m_err;
    logic        m_pulse;
    logic [31:0] m_bitc;

    function automatic logic lfsr_fb(input logic [31:0] s);
        return s[0] ^ s[1] ^ s[21] ^ s[31];
    endfunction

    task automatic model_reset();
        m_sr = '0; m_mode = MLoad; m_fill = 0; m_run = 0; m_miss = 0;
        m_err = 0; m_pulse = 1'b0; m_bitc = '0;
    endtask

    task automatic model_step(input logic b, input logic v, input logic c);
        logic p;
        logic ok;
        m_pulse = 1'b0;
        if (v) begin
            p = lfsr_fb(m_sr);
            if (m_mode == MLoad) begin
                m_sr = {b, m_sr[31:1]};
                m_fill++;
                if (m_fill == 32) begin m_mode = MVerify; m_run = 0; m_fill = 0; end
            end else if (m_mode == MVerify) begin
                ok   = (b == p) && (m_sr != 0);
                m_sr = {b, m_sr[31:1]};
                if (ok) m_run++; else m_run = 0;
                if (m_run == LockCnt) begin m_mode = MLocked; m_miss = 0; end
            end else begin
                m_sr = {p, m_sr[31:1]};
                m_bitc++;
                if (b != p) begin
                    m_pulse = 1'b1;
                    if (m_err < ErrMax) m_err++;
                    m_miss++;
                    if (m_miss == LossThresh) begin m_mode = MLoad; m_fill = 0; end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (c) begin m_err = 0; m_bitc = '0; end
    endtask

    task automatic drive(input logic b, input logic v, input logic c);
        din = b; din_valid = v; clr_cnt = c;
        @(posedge clk);
        model_step(b, v, c);
        #1;
    endtask

    task automatic send_gen(input logic flip, input logic v, input logic c);
        if (v) hist.push_back(gen);
        drive(gen[0] ^ flip, v, c);
        if (v) gen = {lfsr_fb(gen), gen[31:1]};
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        hist.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0; rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++;
        if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", err_pulse); end
        checks++;
        if (err_count !== '0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", err_count); end
        checks++;
        if (state_out !== 32'h0) begin errors++; $display("FAIL reset_state: got %h want 0", state_out); end
`ifdef LFSR_CHECKER_BITCNT_EN
        checks++;
        if (bit_count !== 32'h0) begin errors++; $display("FAIL reset_bitcnt: got %0d want 0", bit_count); end
`endif
        rst = 1'b1;
    endtask

    task automatic test_clean_lock();
        gen = 32'h1;
        for (int i = 1; i <= 64; i++) begin
            send_gen(1'b0, 1'b1, 1'b0);
            if (i == 32) begin
                checks++;
                if (state_out !== 32'h1) begin
                    errors++; $display("FAIL lock_state32: got %h want 00000001", state_out);
                end
            end
            if (i == 63) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", locked); end
            end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b want 1", locked); end
        checks++;
        if (err_count !== '0) begin errors++; $display("FAIL lock_errcnt: got %0d want 0", err_count); end
    endtask

    task automatic test_single_error();
        for (int i = 65; i <= 120; i++) begin
            send_gen(i == 100, 1'b1, 1'b0);
            if (i == 100) begin
                checks++;
                if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b want 1", err_pulse); end
                checks++;
                if (err_count !== 4'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", err_count); end
            end
            if (i == 101) begin
                checks++;
                if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_end: got %b want 0", err_pulse); end
            end
            if (i >= 100) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL single_locked: got %b want 1 bit %0d", locked, i); end
                checks++;
                if (state_out !== hist[hist.size() - 32]) begin
                    errors++;
                    $display("FAIL single_track: got %h want %h bit %0d", state_out, hist[hist.size() - 32], i);
                end
            end
        end
    endtask

    task automatic test_loss_of_lock();
        send_gen(1'b0, 1'b1, 1'b1);
        checks++;
        if (err_count !== '0) begin errors++; $display("FAIL loss_clr: got %0d want 0", err_count); end
        for (int i = 1; i <= 4; i++) begin
            send_gen(1'b1, 1'b1, 1'b0);
            checks++;
            if (locked !== (i < 4)) begin errors++; $display("FAIL loss_locked: got %b miss %0d", locked, i); end
        end
        checks++;
        if (err_count !== 4'd4) begin errors++; $display("FAIL loss_cnt: got %0d want 4", err_count); end
        for (int i = 1; i <= 64; i++) begin
            send_gen(1'b0, 1'b1, 1'b0);
            if (i == 63 || i == 64) begin
                checks++;
                if (locked !== (i == 64)) begin errors++; $display("FAIL relock: got %b after %0d bits", locked, i); end
            end
        end
    endtask

    task automatic test_lockup_gaps();
        logic [31:0] seed;
        logic        r;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            checks++;
            if (locked !== 1'b0) begin errors++; $display("FAIL lockup_locked: got %b bit %0d", locked, i); end
        end
        checks++;
        if (state_out !== 32'h0) begin errors++; $display("FAIL lockup_state: got %h want 0", state_out); end
        do_reset();
        seed = $urandom() | 32'h1;
        gen  = seed;
        for (int vc = 1; vc <= 64; vc++) begin
            send_gen(1'b0, 1'b1, 1'b0);
            if (vc == 32) begin
                checks++;
                if (state_out !== seed) begin errors++; $display("FAIL gaps_state32: got %h want %h", state_out, seed); end
            end
            if (vc == 63 || vc == 64) begin
                checks++;
                if (locked !== (vc == 64)) begin errors++; $display("FAIL gaps_lock: got %b after %0d", locked, vc); end
            end
            r = 1'($urandom());
            drive(r, 1'b0, 1'b0);
            checks++;
            if (state_out !== m_sr) begin errors++; $display("FAIL gaps_frozen: got %h want %h", state_out, m_sr); end
            checks++;
            if (err_pulse !== 1'b0) begin errors++; $display("FAIL gaps_pulse: got %b want 0", err_pulse); end
        end
    endtask

    task automatic test_saturation();
        send_gen(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            send_gen(1'b1, 1'b1, 1'b0);
            checks++;
            if (err_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse: got %b err %0d", err_pulse, i); end
            send_gen(1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (err_count !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d want 15", err_count); end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked: got %b want 1", locked); end
        send_gen(1'b1, 1'b1, 1'b1);
        checks++;
        if (err_count !== '0) begin errors++; $display("FAIL clr_priority: got %0d want 0", err_count); end
        checks++;
        if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_pulse: got %b want 1", err_pulse); end
    endtask

    task automatic test_random();
        logic v, f, c;
        logic [ErrW-1:0] exp_e;
        do_reset();
        gen = $urandom() | 32'h1;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(3, 0) != 0);
            f = ($urandom_range(49, 0) == 0);
            c = ($urandom_range(99, 0) == 0);
            send_gen(f, v, c);
            exp_e = m_err[ErrW-1:0];
            checks++;
            if (locked !== (m_mode == MLocked)) begin
                errors++; $display("FAIL rnd_locked: got %b want %b cyc %0d", locked, m_mode == MLocked, i);
            end
            checks++;
            if (err_pulse !== m_pulse) begin errors++; $display("FAIL rnd_pulse: got %b want %b cyc %0d", err_pulse, m_pulse, i); end
            checks++;
            if (err_count !== exp_e) begin errors++; $display("FAIL rnd_errcnt: got %0d want %0d cyc %0d", err_count, exp_e, i); end
            checks++;
            if (state_out !== m_sr) begin errors++; $display("FAIL rnd_state: got %h want %h cyc %0d", state_out, m_sr, i); end
`ifdef LFSR_CHECKER_BITCNT_EN
            checks++;
            if (bit_count !== m_bitc) begin errors++; $display("FAIL rnd_bitcnt: got %0d want %0d cyc %0d", bit_count, m_bitc, i); end
`endif
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        gen = 32'h1;
        for (int i = 0; i < 64; i++) send_gen(1'b0, 1'b1, 1'b0);
        send_gen(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_gen(1'b0, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_count !== 4'd1) begin
            errors++; $display("FAIL arst_pre: got locked %b cnt %0d want 1 1", locked, err_count);
        end
        din_valid = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL arst_locked: got %b want 0", locked); end
        checks++;
        if (err_count !== '0) begin errors++; $display("FAIL arst_cnt: got %0d want 0", err_count); end
        checks++;
        if (state_out !== 32'h0) begin errors++; $display("FAIL arst_state: got %h want 0", state_out); end
`ifdef LFSR_CHECKER_BITCNT_EN
        checks++;
        if (bit_count !== 32'h0) begin errors++; $display("FAIL arst_bitcnt: got %0d want 0", bit_count); end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (state_out !== 32'h0 || locked !== 1'b0) begin
            errors++; $display("FAIL arst_hold: got state %h locked %b want 0 0", state_out, locked);
        end
        rst = 1'b1;
        din_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_of_lock();
        test_lockup_gaps();
        test_saturation();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
